// File: rtl/rr_arb8_enc_if.sv
// rr_arb8_enc_if
//   Bundles the request/grant signals of the 8-way round-robin arbiter.
//   Handshake: a requester raises req[i] and holds it for as long as it needs
//   the resource; gnt[i] high means it owns the resource this cycle. Dropping
//   req[i] while granted ends the ownership on the next edge. There is no
//   separate ready: the grant itself is the acceptance.
//   Signals:
//     en        arbitration enable (master -> arbiter)
//     req[7:0]  level requests (master -> arbiter)
//     gnt[7:0]  one-hot grant, registered (arbiter -> master)
//     gnt_idx   3-bit index of the granted requester (arbiter -> master)
//     gnt_vld   grant active, equals |gnt (arbiter -> master)
//     tmo       one-cycle pulse after a hold-limit revoke (arbiter -> master)
//     dbg_state FSM state for observation (0 IDLE, 1 GRANT, 2 GAP)
interface rr_arb8_enc_if;
   logic       en;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_vld;
   logic       tmo;
   logic [1:0] dbg_state;

   modport master (
      output en, req,
      input  gnt, gnt_idx, gnt_vld, tmo, dbg_state
   );

   modport slave (
      input  en, req,
      output gnt, gnt_idx, gnt_vld, tmo, dbg_state
   );
endinterface

// File: rtl/rr_arb8_enc.sv
// rr_arb8_enc
//   Round-robin arbiter for 8 requesters. The grant is registered both as a
//   one-hot vector and as a 3-bit index taken straight from the priority
//   search, so the index is always a legal code. After every grant there is
//   one dead GAP cycle before the next arbitration.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    rr_arb8_enc_if.slave (en, req in; gnt, gnt_idx, gnt_vld, tmo,
//            dbg_state out)
//   Parameters:
//     MAX_HOLD  max consecutive grant cycles per owner, 0 = unlimited
//     CNT_W     hold counter width, 2**CNT_W > MAX_HOLD
module rr_arb8_enc #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   rr_arb8_enc_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam bit               HOLD_LIM  = (MAX_HOLD != 0);
   // Value of hold_cnt in the last allowed grant cycle.
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_t           state, state_nx;
   logic [2:0]       ptr, ptr_nx;
   logic [2:0]       idx, idx_nx;
   logic [7:0]       gnt, gnt_nx;
   logic             tmo, tmo_nx;
   logic [CNT_W-1:0] hold_cnt, hold_cnt_nx;

   logic             found;
   logic [2:0]       pick;
   logic [2:0]       cand;
   logic             rel;
   logic             at_limit;

   // Priority search starting at ptr and wrapping modulo 8.
   always_comb begin
      found = 1'b0;
      pick  = 3'd0;
      cand  = 3'd0;
      for (int i = 0; i < 8; i++) begin
         cand = ptr + 3'(i);
         if (!found && bus.req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign at_limit = HOLD_LIM && (hold_cnt == HOLD_LAST);
   assign rel      = !bus.req[idx] || !bus.en || at_limit;

   always_comb begin
      state_nx    = state;
      ptr_nx      = ptr;
      idx_nx      = idx;
      gnt_nx      = gnt;
      tmo_nx      = 1'b0;
      hold_cnt_nx = hold_cnt;
      case (state)
         IDLE: begin
            if (bus.en && found) begin
               idx_nx      = pick;
               gnt_nx      = 8'd1 << pick;
               hold_cnt_nx = '0;
               state_nx    = GRANT;
            end
         end
         GRANT: begin
            if (rel) begin
               gnt_nx   = 8'd0;
               ptr_nx   = idx + 3'd1;
               // Only a hold-limit revoke with the owner still asking counts.
               tmo_nx   = bus.req[idx] && bus.en;
               state_nx = GAP;
            end else if (hold_cnt != '1) begin
               hold_cnt_nx = hold_cnt + 1'b1;
            end
         end
         GAP: begin
            state_nx = IDLE;
         end
         default: begin
            gnt_nx   = 8'd0;
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= 3'd0;
         idx      <= 3'd0;
         gnt      <= 8'd0;
         tmo      <= 1'b0;
         hold_cnt <= '0;
      end else begin
         state    <= state_nx;
         ptr      <= ptr_nx;
         idx      <= idx_nx;
         gnt      <= gnt_nx;
         tmo      <= tmo_nx;
         hold_cnt <= hold_cnt_nx;
      end
   end

   assign bus.gnt       = gnt;
   assign bus.gnt_idx   = idx;
   assign bus.gnt_vld   = |gnt;
   assign bus.tmo       = tmo;
   assign bus.dbg_state = state;

endmodule

// File: tb/tb_rr_arb8_enc.sv
module tb_rr_arb8_enc;
   localparam int MAX_HOLD = 4;
   localparam int W        = 13;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_err;

   logic [W-1:0] exp_q[$];

   rr_arb8_enc_if bus ();

   rr_arb8_enc #(.MAX_HOLD(MAX_HOLD), .CNT_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int         m_st;     // 0 idle, 1 grant, 2 gap
   logic [2:0] m_ptr;
   logic [2:0] m_cur;
   int         m_hold;
   logic       m_tmo;

   function automatic logic [2:0] first_req(input logic [2:0] p, input logic [7:0] r);
      for (int k = 0; k < 8; k++) begin
         if (r[(int'(p) + k) % 8]) return 3'((int'(p) + k) % 8);
      end
      return p;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_st = 0; m_ptr = 3'd0; m_cur = 3'd0; m_hold = 0; m_tmo = 1'b0;
         exp_q.delete();
      end else begin
         logic [7:0] e_gnt;
         m_tmo = 1'b0;
         if (m_st == 0) begin
            if (bus.en && bus.req != 8'd0) begin
               m_cur = first_req(m_ptr, bus.req);
               m_hold = 0;
               m_st = 1;
            end
         end else if (m_st == 1) begin
            if (!bus.req[m_cur] || !bus.en || m_hold == MAX_HOLD - 1) begin
               m_tmo = bus.req[m_cur] && bus.en;
               m_ptr = m_cur + 3'd1;
               m_st = 2;
            end else begin
               m_hold++;
            end
         end else begin
            m_st = 0;
         end
         e_gnt = (m_st == 1) ? (8'd1 << m_cur) : 8'd0;
         exp_q.push_back({e_gnt, m_cur, (m_st == 1), m_tmo});
      end
   end

   // Scoreboard compare and invariants, away from the active edge.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         logic [W-1:0] e;
         e = exp_q.pop_front();
         chk("sb_out", {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo}, e);
      end
      chk("inv_onehot", $onehot0(bus.gnt), 1);
      chk("inv_vld", bus.gnt_vld, |bus.gnt);
      if (bus.gnt_vld) chk("inv_idx", bus.gnt, 8'd1 << bus.gnt_idx);
      if (bus.tmo) chk("inv_tmo", bus.gnt_vld, 0);
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input logic e, input logic [7:0] r);
      bus.en  = e;
      bus.req = r;
   endtask

   task automatic wait_grant(input int bound, output int waited);
      waited = 0;
      while (!bus.gnt_vld && waited < bound) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.gnt_vld) chk("grant_timeout", 0, 1);
   endtask

   task automatic measure_hold(output int h);
      h = 0;
      while (bus.gnt_vld && h < 32) begin
         h++;
         @(negedge clk);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk(tag, {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo}, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int w;
      int h;
      n_chk = 0;
      n_err = 0;
      rst_n = 1'b0;
      drive(1'b1, 8'hFF);

      // 1 reset with all requests high
      tick(3);
      chk_zero("reset_out");
      chk("reset_state", bus.dbg_state, 0);
      drive(1'b1, 8'h00);
      rst_n = 1'b1;
      tick(1);

      // 2 single request, release, gap, ptr moves to 5
      drive(1'b1, 8'h10);
      tick(1);
      chk("single_gnt", bus.gnt, 8'h10);
      chk("single_idx", bus.gnt_idx, 4);
      drive(1'b1, 8'h00);
      tick(1);
      chk("single_rel", bus.gnt, 0);
      chk("single_gap", bus.dbg_state, 2);
      chk("single_tmo", bus.tmo, 0);
      drive(1'b1, 8'h21);
      tick(1);
      chk("single_idle", bus.gnt_vld, 0);
      tick(1);
      chk("ptr5_pick", bus.gnt_idx, 5);
      drive(1'b1, 8'h00);
      tick(3);

      // 3 rotation from ptr 0 with all requests held
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      drive(1'b1, 8'hFF);
      for (int k = 0; k < 9; k++) begin
         wait_grant(10, w);
         if (k > 0) chk("rot_gap", w, 2);
         chk("rot_owner", bus.gnt_idx, k % 8);
         measure_hold(h);
         chk("rot_hold", h, MAX_HOLD);
         chk("rot_tmo", bus.tmo, 1);
      end
      drive(1'b1, 8'h00);
      tick(3);

      // 4 fairness between 7 and 0, starting with ptr 7
      drive(1'b1, 8'h40);
      wait_grant(5, w);
      chk("fair_setup", bus.gnt_idx, 6);
      drive(1'b1, 8'h00);
      tick(3);
      drive(1'b1, 8'h81);
      for (int j = 0; j < 4; j++) begin
         wait_grant(10, w);
         chk("fair_owner", bus.gnt_idx, (j % 2 == 0) ? 7 : 0);
         measure_hold(h);
         chk("fair_hold", h, MAX_HOLD);
      end
      drive(1'b1, 8'h00);
      tick(3);

      // 5 enable revokes and blocks
      drive(1'b1, 8'h04);
      wait_grant(5, w);
      chk("en_gnt", bus.gnt, 8'h04);
      drive(1'b0, 8'h04);
      tick(1);
      chk("en_revoke", bus.gnt, 0);
      chk("en_tmo", bus.tmo, 0);
      drive(1'b0, 8'h01);
      for (int j = 0; j < 10; j++) begin
         tick(1);
         chk("en_block", bus.gnt_vld, 0);
      end
      drive(1'b1, 8'h01);
      wait_grant(4, w);
      chk("en_raise", bus.gnt, 8'h01);
      drive(1'b1, 8'h00);
      tick(3);

      // random traffic, scoreboard only
      for (int j = 0; j < 300; j++) begin
         drive(($urandom_range(0, 7) != 0), 8'($urandom_range(0, 255)));
         tick($urandom_range(1, 6));
      end
      drive(1'b1, 8'h00);
      tick(4);

      // 6 async reset mid-grant
      drive(1'b1, 8'h08);
      wait_grant(5, w);
      chk("arst_pre", bus.gnt, 8'h08);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk_zero("arst_now");
      @(negedge clk);
      rst_n = 1'b1;
      wait_grant(4, w);
      chk("arst_regnt", bus.gnt, 8'h08);
      chk("arst_idx", bus.gnt_idx, 3);
      drive(1'b1, 8'h00);
      tick(4);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
